// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble"),
// one magnitude bit per clock. It sits between the arithmetic unit and the
// display scanner. A conversion is requested with start while idle. The
// result appears WIDTH cycles later, flagged by a one-cycle done pulse. The
// sign code travels alongside the magnitude unchanged.
//
// Ports:
//   clk       system clock, rising edge
//   btnres    synchronous active-high reset; also aborts a running conversion
//   start     conversion request, only looked at while idle
//   bin_in    unsigned magnitude to convert (WIDTH bits)
//   sign_in   2-bit sign code, captured together with bin_in
//   busy      high while a conversion is running (exactly WIDTH cycles)
//   done      one-cycle pulse when bcd_out/sign_out/ovf carry a new result
//   bcd_out   DIGITS packed BCD digits, units digit in [3:0]
//   sign_out  sign code that belongs to the current bcd_out
//   ovf       magnitude did not fit in DIGITS digits (top digit dropped)
//
// The internal BCD field holds DIGITS+1 digits, so the parameters must
// satisfy 10^(DIGITS+1) > 2^WIDTH.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  btnres,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic [1:0]            sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            sign_out,
    output logic                  ovf
);

    localparam int BCD_W   = (DIGITS + 1) * 4;
    localparam int SHIFT_W = BCD_W + WIDTH;
    localparam int CNT_W   = $clog2(WIDTH + 1);

    // Counter value seen on the edge that performs the final shift.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t                state_q, state_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sign_sh_q, sign_sh_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [1:0]            sign_out_q, sign_out_d;
    logic                  ovf_q, ovf_d;

    logic [SHIFT_W-1:0]    adjusted;
    logic [SHIFT_W-1:0]    shifted;

    // The {BCD, binary} register is laid out with the binary field in the
    // low WIDTH bits and the BCD digits above it. Before each shift, every
    // BCD nibble of 5 or more gets 3 added. That way the left shift (a
    // doubling) carries correctly into the next decimal digit instead of
    // producing a nibble of 10..15.
    always_comb begin
        adjusted = shift_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (shift_q[WIDTH + 4*i +: 4] >= 4'd5) begin
                adjusted[WIDTH + 4*i +: 4] = shift_q[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        shifted = adjusted << 1;
    end

    // Next-state logic. IDLE waits for start and loads the operand. CONV
    // shifts one bit per edge. On the last shift, CONV publishes the
    // post-shift digits, the overflow flag and the sign shadow, pulses done,
    // and falls back to IDLE. Because the state is already IDLE while done
    // is high, a start in that cycle is accepted.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        sign_sh_d  = sign_sh_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = {{BCD_W{1'b0}}, bin_in};
                    sign_sh_d = sign_in;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                shift_d = shifted;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // The top digit is dropped from bcd_out, but a nonzero
                    // top digit is reported through ovf.
                    bcd_d      = shifted[WIDTH +: 4*DIGITS];
                    ovf_d      = (shifted[WIDTH + 4*DIGITS +: 4] != 4'd0);
                    sign_out_d = sign_sh_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and all outputs are registered here. Reset clears the
    // previous result too, so an aborted conversion leaves zeros on the
    // display rather than stale digits.
    always_ff @(posedge clk) begin
        if (btnres) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            sign_sh_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            sign_sh_q  <= sign_sh_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign sign_out = sign_out_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Directed bench for bin_to_bcd_seq with WIDTH=20 and DIGITS=6.
//
// The reference model tracks the converter only as a countdown of remaining
// busy cycles. It forms the digits with decimal division, so it never
// mirrors the shift-and-add structure. Every cycle after the first reset,
// the DUT outputs are compared against this model. Hand-computed literals
// pin both the model and the DUT at the interesting points.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;

    logic                clk;
    logic                btnres;
    logic                start;
    logic [WIDTH-1:0]    binIn;
    logic [1:0]          signIn;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcdOut;
    logic [1:0]          signOut;
    logic                ovf;

    int checks;
    int errors;
    int cyc;
    bit checking;

    // Reference model state.
    int unsigned   mRemain;
    int unsigned   mPendV;
    logic [1:0]    mPendS;
    logic          mDone;
    logic [23:0]   mBcd;
    logic [1:0]    mSign;
    logic          mOvf;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .btnres   (btnres),
        .start    (start),
        .bin_in   (binIn),
        .sign_in  (signIn),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcdOut),
        .sign_out (signOut),
        .ovf      (ovf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Plain decimal digit extraction. Only the low DIGITS digits are kept,
    // as on the display.
    function automatic logic [23:0] toBcd(input int unsigned v);
        logic [23:0]  r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Records one comparison and reports a failure if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Behavioural model: idle accepts start, then counts WIDTH cycles down.
    // The result lands on the edge where the count reaches zero.
    always @(posedge clk) begin
        cyc++;
        if (btnres) begin
            mRemain = 0;
            mDone   = 1'b0;
            mBcd    = '0;
            mSign   = '0;
            mOvf    = 1'b0;
            mPendV  = 0;
            mPendS  = '0;
        end else if (mRemain == 0) begin
            mDone = 1'b0;
            if (start) begin
                mRemain = WIDTH;
                mPendV  = int'(binIn);
                mPendS  = signIn;
            end
        end else begin
            mRemain--;
            mDone = 1'b0;
            if (mRemain == 0) begin
                mDone = 1'b1;
                mBcd  = toBcd(mPendV);
                mOvf  = (mPendV >= 1000000);
                mSign = mPendS;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy",     32'(busy),    32'(mRemain != 0));
            checkOutput("done",     32'(done),    32'(mDone));
            checkOutput("bcd_out",  32'(bcdOut),  32'(mBcd));
            checkOutput("sign_out", 32'(signOut), 32'(mSign));
            checkOutput("ovf",      32'(ovf),     32'(mOvf));
        end
    end

    // Presents one start for a single cycle. The task returns at the falling
    // edge just after the edge that sampled start.
    task automatic applyStimulus(input int unsigned v, input logic [1:0] s);
        start  = 1'b1;
        binIn  = WIDTH'(v);
        signIn = s;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Waits for done with a cycle budget and counts busy cycles along the
    // way. The task returns on the falling edge where done is high.
    task automatic waitDone(input string name, output int busyCycles);
        bit seen;
        seen = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput({name, " done seen"}, 32'(seen), 32'd1);
    endtask

    // Checks both the DUT and the model against a hand-computed result.
    task automatic checkResult(input string name, input logic [23:0] expBcd,
                               input logic expOvf, input logic [1:0] expSign);
        checkOutput({name, " bcd"},        32'(bcdOut), 32'(expBcd));
        checkOutput({name, " ovf"},        32'(ovf),    32'(expOvf));
        checkOutput({name, " sign"},       32'(signOut), 32'(expSign));
        checkOutput({name, " model bcd"},  32'(mBcd),   32'(expBcd));
        checkOutput({name, " model ovf"},  32'(mOvf),   32'(expOvf));
    endtask

    initial begin
        int bc;
        int doneCount;
        int t1;
        int t2;
        int t3;
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        checking = 1'b0;
        mRemain  = 0;
        mDone    = 1'b0;
        mBcd     = '0;
        mSign    = '0;
        mOvf     = 1'b0;
        mPendV   = 0;
        mPendS   = '0;
        btnres   = 1'b1;
        start    = 1'b0;
        binIn    = '0;
        signIn   = '0;

        // Reset, including start asserted during reset, which must be ignored.
        @(negedge clk);
        start  = 1'b1;
        binIn  = WIDTH'(5);
        @(negedge clk);
        start  = 1'b0;
        checking = 1'b1;
        checkOutput("reset busy", 32'(busy),   32'd0);
        checkOutput("reset done", 32'(done),   32'd0);
        checkOutput("reset bcd",  32'(bcdOut), 32'd0);
        checkOutput("reset sign", 32'(signOut), 32'd0);
        checkOutput("reset ovf",  32'(ovf),    32'd0);
        btnres = 1'b0;
        @(negedge clk);

        // Zero in: busy for 20 cycles, then a one-cycle done.
        applyStimulus(0, 2'b00);
        waitDone("zero", bc);
        checkOutput("zero busy cycles", 32'(bc), 32'd20);
        checkResult("zero", 24'h000000, 1'b0, 2'b00);
        @(negedge clk);
        checkOutput("zero done width", 32'(done), 32'd0);

        applyStimulus(12345, 2'b01);
        waitDone("12345", bc);
        checkOutput("12345 busy cycles", 32'(bc), 32'd20);
        checkResult("12345", 24'h012345, 1'b0, 2'b01);
        @(negedge clk);
        checkOutput("12345 done width", 32'(done), 32'd0);

        // Around the six-digit boundary.
        applyStimulus(999999, 2'b10);
        waitDone("999999", bc);
        checkResult("999999", 24'h999999, 1'b0, 2'b10);
        @(negedge clk);
        applyStimulus(1000000, 2'b11);
        waitDone("1000000", bc);
        checkResult("1000000", 24'h000000, 1'b1, 2'b11);
        @(negedge clk);
        applyStimulus(1048575, 2'b01);
        waitDone("1048575", bc);
        checkResult("1048575", 24'h048575, 1'b1, 2'b01);
        @(negedge clk);

        // A start pulse in the middle of a conversion is ignored.
        applyStimulus(12345, 2'b00);
        repeat (6) @(negedge clk);
        start = 1'b1;
        binIn = WIDTH'(777);
        @(negedge clk);
        start = 1'b0;
        waitDone("ignored start", bc);
        checkResult("ignored start", 24'h012345, 1'b0, 2'b00);
        // A start raised during the done cycle is accepted.
        applyStimulus(777, 2'b10);
        waitDone("start in done", bc);
        checkOutput("start in done busy", 32'(bc), 32'd20);
        checkResult("start in done", 24'h000777, 1'b0, 2'b10);
        @(negedge clk);

        // Abort a conversion with reset on its tenth cycle.
        applyStimulus(54321, 2'b11);
        repeat (9) @(negedge clk);
        btnres = 1'b1;
        @(negedge clk);
        btnres = 1'b0;
        checkOutput("abort busy", 32'(busy),    32'd0);
        checkOutput("abort bcd",  32'(bcdOut),  32'd0);
        checkOutput("abort sign", 32'(signOut), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) doneCount++;
            @(negedge clk);
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);

        // Start held high continuously: results every 21 cycles.
        start  = 1'b1;
        binIn  = WIDTH'(1);
        signIn = 2'b10;
        waitDone("held 1", bc);
        t1 = cyc;
        checkResult("held 1", 24'h000001, 1'b0, 2'b10);
        binIn = WIDTH'(2);
        @(negedge clk);
        waitDone("held 2", bc);
        t2 = cyc;
        checkResult("held 2", 24'h000002, 1'b0, 2'b10);
        binIn = WIDTH'(3);
        @(negedge clk);
        waitDone("held 3", bc);
        t3 = cyc;
        checkResult("held 3", 24'h000003, 1'b0, 2'b10);
        start = 1'b0;
        checkOutput("held spacing 1", 32'(t2 - t1), 32'd21);
        checkOutput("held spacing 2", 32'(t3 - t2), 32'd21);
        repeat (25) @(negedge clk);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
